// File: rtl/systolic_pkg.sv
// ============================================================================
// Module      : systolic_pkg
// Description : Shared definitions for the weight-stationary systolic tile:
//               controller state encoding, pipeline latency helper and the
//               default parameter values used by the tile, PE and interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam int DEF_ARRAY_SIZE = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Accept-to-result latency: N skew/compute stages plus N deskew/output
    // stages.
    function automatic int calc_latency(input int n);
        return 2 * n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_tile_if.sv
// ============================================================================
// Module      : systolic_tile_if
// Description : Handshake and data bundle of the systolic tile.
//               master : drives weight beats and activation vectors
//               slave  : the tile; returns ready/valid, results and status
// Signals     : load/wload_ready/weights      - weight-row beat channel
//               act_valid/act_ready/activations - activation vector channel
//               out_valid/output_row           - result channel
//               weights_loaded                 - weight matrix resident
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_tile_if
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) ();

    logic                             load;
    logic                             wload_ready;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights;
    logic                             act_valid;
    logic                             act_ready;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations;
    logic                             out_valid;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0]  output_row;
    logic                             weights_loaded;

    modport master (
        output load, weights, act_valid, activations,
        input  wload_ready, act_ready, out_valid, output_row, weights_loaded
    );

    modport slave (
        input  load, weights, act_valid, activations,
        output wload_ready, act_ready, out_valid, output_row, weights_loaded
    );

endinterface

`default_nettype wire

// File: rtl/systolic_pe.sv
// ============================================================================
// Module      : systolic_pe
// Description : One processing element of the weight-stationary grid.
//               Holds a stationary weight (shifted down while loading),
//               forwards the activation east through a register and adds
//               a*w to the partial sum arriving from above.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               w_shift             - capture w_in into the weight register
//               w_in  / w_out       - weight from above / to below
//               a_in  / a_out       - activation from west / to east
//               psum_in / psum_out  - partial sum from above / to below
// Config      : SYSTOLIC_SIGNED_EN selects two's-complement arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  w_shift,
    input  wire logic [DATA_WIDTH-1:0] w_in,
    input  wire logic [DATA_WIDTH-1:0] a_in,
    input  wire logic [ACC_WIDTH-1:0]  psum_in,
    output logic      [DATA_WIDTH-1:0] w_out,
    output logic      [DATA_WIDTH-1:0] a_out,
    output logic      [ACC_WIDTH-1:0]  psum_out
);

    localparam int c_PROD_W = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] r_weight_q, w_weight_d;
    logic [DATA_WIDTH-1:0] r_act_q,    w_act_d;
    logic [ACC_WIDTH-1:0]  r_psum_q,   w_psum_d;
    logic [c_PROD_W-1:0]   w_prod;
    logic [ACC_WIDTH-1:0]  w_prod_ext;

    always_comb begin
        w_weight_d = w_shift ? w_in : r_weight_q;
        w_act_d    = a_in;
`ifdef SYSTOLIC_SIGNED_EN
        // Operands are sign-extended to the product width first, so the
        // low bits of the unsigned multiply are the exact signed product.
        w_prod     = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in}
                   * {{DATA_WIDTH{r_weight_q[DATA_WIDTH-1]}}, r_weight_q};
        w_prod_ext = {{(ACC_WIDTH-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
`else
        w_prod     = {{DATA_WIDTH{1'b0}}, a_in}
                   * {{DATA_WIDTH{1'b0}}, r_weight_q};
        w_prod_ext = {{(ACC_WIDTH-c_PROD_W){1'b0}}, w_prod};
`endif
        w_psum_d   = psum_in + w_prod_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_weight_q <= '0;
            r_act_q    <= '0;
            r_psum_q   <= '0;
        end else begin
            r_weight_q <= w_weight_d;
            r_act_q    <= w_act_d;
            r_psum_q   <= w_psum_d;
        end
    end

    assign w_out    = r_weight_q;
    assign a_out    = r_act_q;
    assign psum_out = r_psum_q;

endmodule

`default_nettype wire

// File: rtl/systolic_tile.sv
// ============================================================================
// Module      : systolic_tile
// Description : Weight-stationary NxN systolic matrix-vector tile.
//               Weight rows shift in from the top; activation lane r enters
//               row r after an r-cycle skew, partial sums flow down, and the
//               column sums are deskewed so all columns emerge together
//               2*N cycles after the vector was accepted.
// Ports       : clk    - clock
//               reset  - synchronous active-high reset
//               bus    - systolic_tile_if.slave (weight, activation and
//                        result channels plus weights_loaded status)
// Config      : SYSTOLIC_SIGNED_EN selects two's-complement arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_tile
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       reset,
    systolic_tile_if.slave  bus
);

    localparam int c_LATENCY = calc_latency(ARRAY_SIZE);
    localparam int c_BEAT_W  = $clog2(ARRAY_SIZE);
    localparam int c_CNT_W   = $clog2(c_LATENCY + 1);

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    state_e                          r_state_q,     w_state_d;
    logic [c_BEAT_W-1:0]             r_beat_q,      w_beat_d;
    logic [c_CNT_W-1:0]              r_inflight_q,  w_inflight_d;
    logic [c_LATENCY-1:0]            r_vpipe_q,     w_vpipe_d;
    logic                            r_out_valid_q, w_out_valid_d;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0] r_out_row_q,   w_out_row_d;

    logic w_wload_ready;
    logic w_act_ready;
    logic w_beat;
    logic w_accept;
    logic w_emit;

    // ------------------------------------------------------------------
    // Datapath interconnect
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]           w_a_link  [ARRAY_SIZE][ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]           w_w_link  [ARRAY_SIZE][ARRAY_SIZE];
    logic [ACC_WIDTH-1:0]            w_ps_link [ARRAY_SIZE][ARRAY_SIZE];
    logic [ACC_WIDTH-1:0]            w_col_sum [ARRAY_SIZE];
    logic [ARRAY_SIZE*ACC_WIDTH-1:0] w_col_row;
    // Activations leaving the east edge and weights leaving the bottom edge
    // have nowhere to go.
    logic [DATA_WIDTH-1:0]           w_east_unused   [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]           w_bottom_unused [ARRAY_SIZE];

    assign w_wload_ready = (r_state_q == ST_IDLE) || (r_state_q == ST_LOAD) ||
                           ((r_state_q == ST_READY) && (r_inflight_q == '0));
    // A pending weight beat takes priority over a waiting activation vector.
    assign w_act_ready   = (r_state_q == ST_READY) && !bus.load;
    assign w_beat        = bus.load && w_wload_ready;
    assign w_accept      = bus.act_valid && w_act_ready;
    // A result leaves the deskew stage on the edge that sets out_valid.
    assign w_emit        = r_vpipe_q[c_LATENCY-1];

    always_comb begin
        w_state_d = r_state_q;
        w_beat_d  = r_beat_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_beat) begin
                    w_state_d = ST_LOAD;
                    w_beat_d  = c_BEAT_W'(1);
                end
            end
            ST_LOAD: begin
                if (w_beat) begin
                    if (r_beat_q == c_BEAT_W'(ARRAY_SIZE - 1)) begin
                        w_state_d = ST_READY;
                        w_beat_d  = '0;
                    end else begin
                        w_beat_d  = r_beat_q + 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (bus.load) begin
                    if (r_inflight_q == '0) begin
                        w_state_d = ST_LOAD;
                        w_beat_d  = c_BEAT_W'(1);
                    end else begin
                        w_state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_inflight_q == '0) begin
                    w_state_d = ST_LOAD;
                    w_beat_d  = '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_beat_d  = '0;
            end
        endcase

        case ({w_accept, w_emit})
            2'b10:   w_inflight_d = r_inflight_q + 1'b1;
            2'b01:   w_inflight_d = r_inflight_q - 1'b1;
            default: w_inflight_d = r_inflight_q;
        endcase

        w_vpipe_d     = {r_vpipe_q[c_LATENCY-2:0], w_accept};
        w_out_valid_d = w_emit;
        w_out_row_d   = w_emit ? w_col_row : r_out_row_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_beat_q      <= '0;
            r_inflight_q  <= '0;
            r_vpipe_q     <= '0;
            r_out_valid_q <= 1'b0;
            r_out_row_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_beat_q      <= w_beat_d;
            r_inflight_q  <= w_inflight_d;
            r_vpipe_q     <= w_vpipe_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_row_q   <= w_out_row_d;
        end
    end

    // ------------------------------------------------------------------
    // Input skew: lane r passes through r+1 registers. Idle cycles load
    // zeros so bubbles contribute nothing to the column sums.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_skew
        logic [DATA_WIDTH-1:0] r_skew_q [0:r];
        logic [DATA_WIDTH-1:0] w_skew_d [0:r];

        always_comb begin
            w_skew_d[0] = w_accept ? bus.activations[r*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int k = 1; k <= r; k++) begin
                w_skew_d[k] = r_skew_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= r; k++) begin
                    r_skew_q[k] <= '0;
                end
            end else begin
                r_skew_q <= w_skew_d;
            end
        end

        assign w_a_link[r][0] = r_skew_q[r];
    end

    // Top edge: new weight row enters row 0, partial sums start at zero.
    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_top
        assign w_w_link[0][c]  = bus.weights[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_ps_link[0][c] = '0;
    end

    // ------------------------------------------------------------------
    // PE grid
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
            logic [DATA_WIDTH-1:0] w_a_out;
            logic [DATA_WIDTH-1:0] w_w_out;
            logic [ACC_WIDTH-1:0]  w_ps_out;

            systolic_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk      (clk),
                .reset    (reset),
                .w_shift  (w_beat),
                .w_in     (w_w_link[r][c]),
                .a_in     (w_a_link[r][c]),
                .psum_in  (w_ps_link[r][c]),
                .w_out    (w_w_out),
                .a_out    (w_a_out),
                .psum_out (w_ps_out)
            );

            if (c < ARRAY_SIZE - 1) begin : g_east
                assign w_a_link[r][c+1] = w_a_out;
            end else begin : g_east_edge
                assign w_east_unused[r] = w_a_out;
            end

            if (r < ARRAY_SIZE - 1) begin : g_down
                assign w_w_link[r+1][c]  = w_w_out;
                assign w_ps_link[r+1][c] = w_ps_out;
            end else begin : g_bottom_edge
                assign w_bottom_unused[c] = w_w_out;
                assign w_col_sum[c]       = w_ps_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output deskew: column c finishes c cycles after column 0, so it is
    // delayed by N-1-c cycles to line all columns up.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_deskew
        localparam int c_DEPTH = ARRAY_SIZE - 1 - c;

        if (c_DEPTH == 0) begin : g_pass
            assign w_col_row[c*ACC_WIDTH +: ACC_WIDTH] = w_col_sum[c];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] r_dly_q [c_DEPTH];
            logic [ACC_WIDTH-1:0] w_dly_d [c_DEPTH];

            always_comb begin
                w_dly_d[0] = w_col_sum[c];
                for (int k = 1; k < c_DEPTH; k++) begin
                    w_dly_d[k] = r_dly_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < c_DEPTH; k++) begin
                        r_dly_q[k] <= '0;
                    end
                end else begin
                    r_dly_q <= w_dly_d;
                end
            end

            assign w_col_row[c*ACC_WIDTH +: ACC_WIDTH] = r_dly_q[c_DEPTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign bus.wload_ready    = w_wload_ready;
    assign bus.act_ready      = w_act_ready;
    assign bus.out_valid      = r_out_valid_q;
    assign bus.output_row     = r_out_row_q;
    assign bus.weights_loaded = (r_state_q == ST_READY) || (r_state_q == ST_DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_systolic_tile.sv
// ============================================================================
// Module      : tb_systolic_tile
// Description : Self-checking bench for systolic_tile (N=2, DW=4, AW=9).
//               Accepted vectors push their expected row and due cycle into
//               a scoreboard; the result monitor pops and compares.
// Config      : SYSTOLIC_SIGNED_EN switches the reference model to signed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_tile;

    localparam int N  = 2;
    localparam int DW = 4;
    localparam int AW = 9;

    typedef struct {
        logic [17:0] row;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [17:0] last_row = '0;
    int   wmat [2][2] = '{'{1, 2}, '{3, 4}};

    systolic_tile_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    systolic_tile #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lane_val(input logic [3:0] x);
`ifdef SYSTOLIC_SIGNED_EN
        return x[3] ? int'(x) - 16 : int'(x);
`else
        return int'(x);
`endif
    endfunction

    function automatic logic [17:0] model_row(input logic [3:0] a0, input logic [3:0] a1);
        int s0;
        int s1;
        s0 = lane_val(a0) * wmat[0][0] + lane_val(a1) * wmat[1][0];
        s1 = lane_val(a0) * wmat[0][1] + lane_val(a1) * wmat[1][1];
        return {s1[8:0], s0[8:0]};
    endfunction

    // Result monitor
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("row", bus.output_row, e.row);
                check_eq("latency", cyc, e.due);
                last_row = e.row;
            end
        end
    end

    // Apply one cycle of stimulus, then wait past the following edge.
    task automatic drive(input logic ld, input logic [7:0] w, input logic av,
                         input logic [7:0] a, input logic rs);
        exp_t e;
        reset           = rs;
        bus.load        = ld;
        bus.weights     = w;
        bus.act_valid   = av;
        bus.activations = a;
        #1;
        if (av && bus.act_ready && !rs) begin
            e.row = model_row(a[3:0], a[7:4]);
            e.due = cyc + 1 + 2 * N;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 16) begin
            drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            k++;
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq({tag, "_drain"}, sb.size(), 0);
    endtask

    initial begin
        int t;

        // Reset
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check_eq("rst_wload_ready", bus.wload_ready, 1);
        check_eq("rst_act_ready", bus.act_ready, 0);
        check_eq("rst_weights_loaded", bus.weights_loaded, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_output_row", bus.output_row, 0);

        // Weight load: beat {4,3} then {2,1}
        drive(1'b1, {4'd4, 4'd3}, 1'b0, 8'h00, 1'b0);
        bus.load = 1'b0;
        #1;
        check_eq("load1_act_ready", bus.act_ready, 0);
        check_eq("load1_weights_loaded", bus.weights_loaded, 0);
        check_eq("load1_wload_ready", bus.wload_ready, 1);
        drive(1'b1, {4'd2, 4'd1}, 1'b0, 8'h00, 1'b0);
        bus.load = 1'b0;
        #1;
        check_eq("load2_act_ready", bus.act_ready, 1);
        check_eq("load2_weights_loaded", bus.weights_loaded, 1);
        check_eq("load2_wload_ready", bus.wload_ready, 1);

        // Single vector {a1=2, a0=3}, then hold check
        drive(1'b0, 8'h00, 1'b1, {4'd2, 4'd3}, 1'b0);
        drain("single");
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("hold_out_valid", bus.out_valid, 0);
        check_eq("hold_output_row", bus.output_row, last_row);

        // Back-to-back vectors
        drive(1'b0, 8'h00, 1'b1, {4'd0, 4'd1}, 1'b0);
        drive(1'b0, 8'h00, 1'b1, {4'd2, 4'd3}, 1'b0);
        drive(1'b0, 8'h00, 1'b1, {4'd4, 4'd0}, 1'b0);
        drain("b2b");

        // Negative under the signed build, 15 under the unsigned one
        drive(1'b0, 8'h00, 1'b1, {4'd0, 4'hF}, 1'b0);
        drain("sign");

        // Reload while a vector is in flight; act_valid held high throughout
        drive(1'b0, 8'h00, 1'b1, {4'd2, 4'd3}, 1'b0);
        t = cyc;
        for (int k = 1; k <= 7; k++) begin
            bus.load        = 1'b1;
            bus.weights     = (k <= 6) ? {4'd4, 4'd3} : {4'd2, 4'd1};
            bus.act_valid   = 1'b1;
            bus.activations = {4'd1, 4'd1};
            #1;
            check_eq($sformatf("reload_act_ready_%0d", k), bus.act_ready, 0);
            check_eq($sformatf("reload_wload_ready_%0d", k), bus.wload_ready, (k >= 6) ? 1 : 0);
            check_eq($sformatf("reload_weights_loaded_%0d", k), bus.weights_loaded, (k <= 5) ? 1 : 0);
            @(negedge clk);
        end
        check_eq("reload_elapsed", cyc - t, 7);
        check_eq("reload_sb_empty", sb.size(), 0);
        bus.load      = 1'b0;
        bus.act_valid = 1'b0;
        #1;
        check_eq("reload_done_weights_loaded", bus.weights_loaded, 1);
        check_eq("reload_done_act_ready", bus.act_ready, 1);
        drive(1'b0, 8'h00, 1'b1, {4'd4, 4'd0}, 1'b0);
        drain("reload");

        // Reset two cycles after an accept: the result must never appear
        drive(1'b0, 8'h00, 1'b1, {4'd2, 4'd3}, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        sb.delete();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check_eq("rstfl_weights_loaded", bus.weights_loaded, 0);
        check_eq("rstfl_wload_ready", bus.wload_ready, 1);
        check_eq("rstfl_act_ready", bus.act_ready, 0);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("rstfl_out_valid_%0d", k), bus.out_valid, 0);
            drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        end

        check_eq("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
